// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported memory between instruction fetch (IF)
//               and the data-memory stage (DM), one transaction at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MAX_DBURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    // fetch port
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    // data port
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_valid,
    // memory side
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    // hazard unit
    output logic          stall_f,
    output logic          stall_m
);

    localparam int CW = $clog2(MAX_DBURST + 1);
    localparam logic [CW-1:0] c_MAX_DBURST = CW'(MAX_DBURST);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY_IF = 2'd1,
        S_BUSY_DM = 2'd2
    } state_t;

    state_t          r_state_q,     w_state_d;
    logic            r_mem_req_q,   w_mem_req_d;
    logic            r_mem_we_q,    w_mem_we_d;
    logic [AW-1:0]   r_mem_addr_q,  w_mem_addr_d;
    logic [DW-1:0]   r_mem_wdata_q, w_mem_wdata_d;
    logic [DW-1:0]   r_if_rdata_q,  w_if_rdata_d;
    logic            r_if_valid_q,  w_if_valid_d;
    logic [DW-1:0]   r_dm_rdata_q,  w_dm_rdata_d;
    logic            r_dm_valid_q,  w_dm_valid_d;
    logic [CW-1:0]   r_starve_q,    w_starve_d;
    logic            r_drop_q,      w_drop_d;

    logic            w_if_elig;
    logic            w_dm_elig;
    logic            w_starved;

    // A requester is not re-granted in the cycle its own response is pulsing.
    assign w_if_elig = if_req & ~r_if_valid_q & ~if_flush;
    assign w_dm_elig = dm_req & ~r_dm_valid_q;
    assign w_starved = (r_starve_q >= c_MAX_DBURST);

    always_comb begin
        w_state_d     = r_state_q;
        w_mem_req_d   = r_mem_req_q;
        w_mem_we_d    = r_mem_we_q;
        w_mem_addr_d  = r_mem_addr_q;
        w_mem_wdata_d = r_mem_wdata_q;
        w_if_rdata_d  = r_if_rdata_q;
        w_if_valid_d  = 1'b0;
        w_dm_rdata_d  = r_dm_rdata_q;
        w_dm_valid_d  = 1'b0;
        w_starve_d    = r_starve_q;
        w_drop_d      = r_drop_q;

        case (r_state_q)
            S_IDLE: begin
                if (w_if_elig && (!w_dm_elig || w_starved)) begin
                    w_state_d     = S_BUSY_IF;
                    w_mem_req_d   = 1'b1;
                    w_mem_we_d    = 1'b0;
                    w_mem_addr_d  = if_addr;
                    w_mem_wdata_d = '0;
                    w_starve_d    = '0;
                    w_drop_d      = 1'b0;
                end else if (w_dm_elig) begin
                    w_state_d     = S_BUSY_DM;
                    w_mem_req_d   = 1'b1;
                    w_mem_we_d    = dm_we;
                    w_mem_addr_d  = dm_addr;
                    w_mem_wdata_d = dm_wdata;
                    if (if_req && (r_starve_q != c_MAX_DBURST)) begin
                        w_starve_d = r_starve_q + 1'b1;
                    end
                end
            end

            S_BUSY_IF: begin
                if (if_flush) begin
                    w_drop_d = 1'b1;
                end
                if (mem_ready) begin
                    w_state_d   = S_IDLE;
                    w_mem_req_d = 1'b0;
                    w_drop_d    = 1'b0;
                    // A flush arriving on the completion cycle also discards the fetch.
                    if (!(r_drop_q || if_flush)) begin
                        w_if_valid_d = 1'b1;
                        w_if_rdata_d = mem_rdata;
                    end
                end
            end

            S_BUSY_DM: begin
                if (mem_ready) begin
                    w_state_d    = S_IDLE;
                    w_mem_req_d  = 1'b0;
                    w_dm_valid_d = 1'b1;
                    if (!r_mem_we_q) begin
                        w_dm_rdata_d = mem_rdata;
                    end
                end
            end

            default: begin
                w_state_d   = S_IDLE;
                w_mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q     <= S_IDLE;
            r_mem_req_q   <= 1'b0;
            r_mem_we_q    <= 1'b0;
            r_mem_addr_q  <= '0;
            r_mem_wdata_q <= '0;
            r_if_rdata_q  <= '0;
            r_if_valid_q  <= 1'b0;
            r_dm_rdata_q  <= '0;
            r_dm_valid_q  <= 1'b0;
            r_starve_q    <= '0;
            r_drop_q      <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_mem_req_q   <= w_mem_req_d;
            r_mem_we_q    <= w_mem_we_d;
            r_mem_addr_q  <= w_mem_addr_d;
            r_mem_wdata_q <= w_mem_wdata_d;
            r_if_rdata_q  <= w_if_rdata_d;
            r_if_valid_q  <= w_if_valid_d;
            r_dm_rdata_q  <= w_dm_rdata_d;
            r_dm_valid_q  <= w_dm_valid_d;
            r_starve_q    <= w_starve_d;
            r_drop_q      <= w_drop_d;
        end
    end

    assign mem_req   = r_mem_req_q;
    assign mem_we    = r_mem_we_q;
    assign mem_addr  = r_mem_addr_q;
    assign mem_wdata = r_mem_wdata_q;
    assign if_rdata  = r_if_rdata_q;
    assign if_valid  = r_if_valid_q;
    assign dm_rdata  = r_dm_rdata_q;
    assign dm_valid  = r_dm_valid_q;

    assign stall_f = if_req & ~r_if_valid_q;
    assign stall_m = dm_req & ~r_dm_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench with a scoreboard for the
//               IF/DM memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_flush, if_valid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_valid;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall_f, stall_m;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .MAX_DBURST(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall_f(stall_f), .stall_m(stall_m)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } mreq_t;

    mreq_t       exp_mem[$];
    logic [31:0] exp_if[$];
    logic [31:0] exp_dm[$];

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memdata(input logic [31:0] a);
        if (a == 32'h100) return 32'h0050_0093;
        return {a[15:0], 16'hC0DE} ^ 32'h1234_0000;
    endfunction

    task automatic push_mem(input logic [31:0] a, input logic we, input logic [31:0] wd);
        mreq_t e;
        e.addr = a; e.we = we; e.wdata = wd;
        exp_mem.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_if(input int max, output int n);
        n = 0;
        while (!if_valid && n < max) begin tick(); n++; end
        chk("if_valid_seen", {31'd0, if_valid}, 32'd1);
    endtask

    task automatic wait_dm(input int max, output int n);
        n = 0;
        while (!dm_valid && n < max) begin tick(); n++; end
        chk("dm_valid_seen", {31'd0, dm_valid}, 32'd1);
    endtask

    // Memory model: answers two cycles after mem_req first appears.
    bit mem_auto = 1'b1;
    int lat_cnt  = 0;
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_auto) begin
                if (mem_ready) begin
                    mem_ready = 1'b0;
                    lat_cnt   = 0;
                end else if (mem_req) begin
                    lat_cnt++;
                    if (lat_cnt == 3) begin
                        mem_ready = 1'b1;
                        mem_rdata = memdata(mem_addr);
                    end
                end else begin
                    lat_cnt = 0;
                end
            end
        end
    end

    // Scoreboard monitor: new memory requests and response pulses.
    mreq_t       mon_e;
    logic        prev_req  = 1'b0;
    logic [31:0] prev_addr = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (mem_req && !prev_req) begin
                if (exp_mem.size() == 0) begin
                    chk("mem_unexpected_req", {31'd0, mem_req}, 32'd0);
                end else begin
                    mon_e = exp_mem.pop_front();
                    chk("mem_addr", mem_addr, mon_e.addr);
                    chk("mem_we", {31'd0, mem_we}, {31'd0, mon_e.we});
                    if (mon_e.we) chk("mem_wdata", mem_wdata, mon_e.wdata);
                end
            end else if (mem_req && prev_req) begin
                chk("mem_addr_hold", mem_addr, prev_addr);
            end
            prev_req  = mem_req;
            prev_addr = mem_addr;
            if (if_valid) begin
                if (exp_if.size() == 0) chk("if_unexpected_valid", {31'd0, if_valid}, 32'd0);
                else chk("if_rdata", if_rdata, exp_if.pop_front());
            end
            if (dm_valid) begin
                if (exp_dm.size() == 0) chk("dm_unexpected_valid", {31'd0, dm_valid}, 32'd0);
                else chk("dm_rdata", dm_rdata, exp_dm.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; if_req = 0; if_addr = 0; if_flush = 0;
        dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        tick(); tick();
        chk("rst_mem_req",  {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we",   {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_dm_valid", {31'd0, dm_valid}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        reset = 1'b0;
        tick();

        // 1: fetch only
        if_req = 1; if_addr = 32'h100;
        push_mem(32'h100, 1'b0, 32'd0);
        exp_if.push_back(32'h0050_0093);
        #1 chk("t1_stall_f_on", {31'd0, stall_f}, 32'd1);
        tick();
        chk("t1_mem_req_lat", {31'd0, mem_req}, 32'd1);
        chk("t1_mem_we", {31'd0, mem_we}, 32'd0);
        wait_if(20, n);
        chk("t1_valid_latency", 32'(n), 32'd3);
        chk("t1_stall_f_off", {31'd0, stall_f}, 32'd0);
        if_req = 0;
        tick();
        chk("t1_valid_pulse", {31'd0, if_valid}, 32'd0);
        chk("t1_rdata_hold", if_rdata, 32'h0050_0093);

        // 2: simultaneous requests, DM first
        dm_req = 1; dm_we = 0; dm_addr = 32'h200;
        if_req = 1; if_addr = 32'h104;
        push_mem(32'h200, 1'b0, 32'd0);
        push_mem(32'h104, 1'b0, 32'd0);
        exp_dm.push_back(memdata(32'h200));
        exp_if.push_back(memdata(32'h104));
        tick();
        chk("t2_dm_first", mem_addr, 32'h200);
        chk("t2_stall_m", {31'd0, stall_m}, 32'd1);
        wait_dm(20, n);
        dm_req = 0;
        chk("t2_gap", {31'd0, mem_req}, 32'd0);
        tick();
        chk("t2_if_grant", {31'd0, mem_req}, 32'd1);
        chk("t2_if_addr", mem_addr, 32'h104);
        wait_if(20, n);
        if_req = 0;
        tick();

        // 3: store leaves dm_rdata untouched
        dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
        push_mem(32'h40, 1'b1, 32'hDEAD_BEEF);
        exp_dm.push_back(memdata(32'h200));
        tick();
        chk("t3_mem_we", {31'd0, mem_we}, 32'd1);
        chk("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        wait_dm(20, n);
        chk("t3_rdata_kept", dm_rdata, memdata(32'h200));
        dm_req = 0; dm_we = 0;
        tick();

        // 4: starvation - four DM grants, then IF forced
        if_req = 1; if_addr = 32'h180;
        dm_req = 1; dm_addr = 32'h20;
        for (int k = 0; k < 4; k++) begin
            push_mem(32'h20, 1'b0, 32'd0);
            exp_dm.push_back(memdata(32'h20));
        end
        push_mem(32'h180, 1'b0, 32'd0);
        exp_if.push_back(memdata(32'h180));
        push_mem(32'h20, 1'b0, 32'd0);
        exp_dm.push_back(memdata(32'h20));
        for (int k = 0; k < 4; k++) begin
            wait_dm(20, n);
            if_flush = 1;
            tick();
            if_flush = 0;
        end
        chk("t4_counter_max", 32'(dut.r_starve_q), 32'd4);
        tick();
        chk("t4_if_wins", mem_addr, 32'h180);
        chk("t4_counter_clr", 32'(dut.r_starve_q), 32'd0);
        wait_if(20, n);
        if_req = 0;
        wait_dm(20, n);
        dm_req = 0;
        chk("t4_counter_after", 32'(dut.r_starve_q), 32'd0);
        tick();

        // 5: flush while fetch in flight
        if_req = 1; if_addr = 32'h280;
        push_mem(32'h280, 1'b0, 32'd0);
        tick();
        chk("t5_busy", {31'd0, mem_req}, 32'd1);
        if_flush = 1; if_req = 0;
        tick();
        if_flush = 0;
        n = 0;
        while (mem_req && n < 20) begin tick(); n++; end
        chk("t5_done", {31'd0, mem_req}, 32'd0);
        chk("t5_no_valid", {31'd0, if_valid}, 32'd0);
        tick();
        chk("t5_no_valid2", {31'd0, if_valid}, 32'd0);
        chk("t5_rdata_kept", if_rdata, memdata(32'h180));
        if_req = 1; if_addr = 32'h300;
        push_mem(32'h300, 1'b0, 32'd0);
        exp_if.push_back(memdata(32'h300));
        wait_if(20, n);
        if_req = 0;
        tick();

        // 6: reset in BUSY_DM, late mem_ready ignored
        mem_auto = 1'b0;
        dm_req = 1; dm_we = 0; dm_addr = 32'h60;
        push_mem(32'h60, 1'b0, 32'd0);
        tick();
        chk("t6_busy", {31'd0, mem_req}, 32'd1);
        tick();
        reset = 1; dm_req = 0;
        tick();
        chk("t6_req_drop", {31'd0, mem_req}, 32'd0);
        chk("t6_rdata_rst", dm_rdata, 32'd0);
        reset = 0; mem_ready = 1; mem_rdata = 32'h1234_5678;
        tick();
        mem_ready = 0;
        chk("t6_no_valid", {31'd0, dm_valid}, 32'd0);
        chk("t6_idle", {31'd0, mem_req}, 32'd0);
        tick();
        chk("t6_no_valid2", {31'd0, dm_valid}, 32'd0);
        chk("t6_rdata_zero", dm_rdata, 32'd0);

        chk("sb_mem_empty", 32'(exp_mem.size()), 32'd0);
        chk("sb_if_empty", 32'(exp_if.size()), 32'd0);
        chk("sb_dm_empty", 32'(exp_dm.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
